board_reset_sequencer: RTL and testbench

//  Board bring-up controller between the PCIe hard-IP reset pin, the kernel PLL and the DDR3/QDRII

---
 rtl/board_reset_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_board_reset_sequencer.sv | 459 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/board_reset_sequencer.sv
// Board bring-up reset sequencer: debounces PERST# and releases global,
// memory and kernel resets in order behind PLL lock and memory calibration.
module board_reset_sequencer #(
    parameter int NUM_MEM            = 4,
    parameter int PERST_DEBOUNCE_CYC = 1024,
    parameter int RESET_HOLD_CYC     = 16,
    parameter int TIMEOUT_CYC        = 2**24
) (
    input  logic               clk_clk,
    input  logic               reset_reset,
    input  logic               pcie_perst_n,
    input  logic               pll_locked,
    input  logic [NUM_MEM-1:0] mem_enable,
    input  logic [NUM_MEM-1:0] mem_cal_success,
    input  logic [NUM_MEM-1:0] mem_cal_fail,
    output logic               global_reset_n,
    output logic               mem_reset_n,
    output logic               kernel_reset_n,
    output logic [2:0]         seq_state,
    output logic [1:0]         err_code,
    output logic [NUM_MEM-1:0] fail_mask,
    output logic [7:0]         leds
);

    localparam int MAX_A = (PERST_DEBOUNCE_CYC > RESET_HOLD_CYC) ?
                           PERST_DEBOUNCE_CYC : RESET_HOLD_CYC;
    localparam int MAX_CYC = (MAX_A > TIMEOUT_CYC) ? MAX_A : TIMEOUT_CYC;
    localparam int CW = $clog2(MAX_CYC) + 1;

    localparam logic [CW-1:0] DEB_LAST  = CW'(PERST_DEBOUNCE_CYC - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(RESET_HOLD_CYC - 1);
    localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_RESET      = 3'd0,
        S_WAIT_PERST = 3'd1,
        S_DEBOUNCE   = 3'd2,
        S_HOLD       = 3'd3,
        S_WAIT_PLL   = 3'd4,
        S_WAIT_CAL   = 3'd5,
        S_RUN        = 3'd6,
        S_ERROR      = 3'd7
    } state_e;

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               perst_meta_q, perst_sync_q;
    logic               pll_meta_q, pll_sync_q;
    logic [NUM_MEM-1:0] succ_meta_q, succ_sync_q;
    logic [NUM_MEM-1:0] fail_meta_q, fail_sync_q;
    logic [1:0]         err_q, err_d;
    logic [NUM_MEM-1:0] mask_q, mask_d;
    logic               glb_q, glb_d;
    logic               memr_q, memr_d;
    logic               krn_q, krn_d;
    logic               cal_fail, cal_done;
    logic [3:0]         cal_led;

    // mem_enable is strap-static, so it is used unsynchronised
    assign cal_fail = |(fail_sync_q & mem_enable);
    assign cal_done = &(succ_sync_q | ~mem_enable);

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            perst_meta_q <= 1'b0;
            perst_sync_q <= 1'b0;
            pll_meta_q   <= 1'b0;
            pll_sync_q   <= 1'b0;
            succ_meta_q  <= '0;
            succ_sync_q  <= '0;
            fail_meta_q  <= '0;
            fail_sync_q  <= '0;
        end else begin
            perst_meta_q <= pcie_perst_n;
            perst_sync_q <= perst_meta_q;
            pll_meta_q   <= pll_locked;
            pll_sync_q   <= pll_meta_q;
            succ_meta_q  <= mem_cal_success;
            succ_sync_q  <= succ_meta_q;
            fail_meta_q  <= mem_cal_fail;
            fail_sync_q  <= fail_meta_q;
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_q <= S_RESET;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == S_RESET) begin
            state_d = S_WAIT_PERST;
        end else if (!perst_sync_q && state_q != S_WAIT_PERST) begin
            state_d = S_WAIT_PERST;
        end else begin
            unique case (state_q)
                S_WAIT_PERST: if (perst_sync_q) state_d = S_DEBOUNCE;
                S_DEBOUNCE:   if (cnt_q == DEB_LAST) state_d = S_HOLD;
                S_HOLD:       if (cnt_q == HOLD_LAST) state_d = S_WAIT_PLL;
                S_WAIT_PLL: begin
                    if (pll_sync_q)            state_d = S_WAIT_CAL;
                    else if (cnt_q == TO_LAST) state_d = S_ERROR;
                end
                S_WAIT_CAL: begin
                    if (cal_fail)              state_d = S_ERROR;
                    else if (cal_done)         state_d = S_RUN;
                    else if (cnt_q == TO_LAST) state_d = S_ERROR;
                end
                S_RUN:        if (!pll_sync_q) state_d = S_HOLD;
                default: ;
            endcase
        end

        if (state_d != state_q) cnt_d = '0;
        else if (cnt_q != '1)   cnt_d = cnt_q + 1'b1;
        else                    cnt_d = cnt_q;
    end

    always_comb begin
        glb_d  = 1'b0;
        memr_d = 1'b0;
        krn_d  = 1'b0;
        unique case (state_d)
            S_WAIT_PLL, S_ERROR: glb_d = 1'b1;
            S_WAIT_CAL: begin
                glb_d  = 1'b1;
                memr_d = 1'b1;
            end
            S_RUN: begin
                glb_d  = 1'b1;
                memr_d = 1'b1;
                krn_d  = 1'b1;
            end
            default: ;
        endcase

        err_d  = err_q;
        mask_d = mask_q;
        if (state_d == S_HOLD && state_q != S_HOLD) begin
            err_d  = 2'd0;
            mask_d = '0;
        end else if (state_d == S_ERROR && state_q == S_WAIT_PLL) begin
            err_d = 2'd1;
        end else if (state_d == S_ERROR && state_q == S_WAIT_CAL) begin
            if (cal_fail) begin
                err_d  = 2'd2;
                mask_d = fail_sync_q & mem_enable;
            end else begin
                err_d = 2'd3;
            end
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            glb_q  <= 1'b0;
            memr_q <= 1'b0;
            krn_q  <= 1'b0;
            err_q  <= 2'd0;
            mask_q <= '0;
        end else begin
            glb_q  <= glb_d;
            memr_q <= memr_d;
            krn_q  <= krn_d;
            err_q  <= err_d;
            mask_q <= mask_d;
        end
    end

    always_comb begin
        cal_led = '0;
        cal_led[NUM_MEM-1:0] = succ_sync_q & mem_enable;
    end

    assign global_reset_n = glb_q;
    assign mem_reset_n    = memr_q;
    assign kernel_reset_n = krn_q;
    assign seq_state      = state_q;
    assign err_code       = err_q;
    assign fail_mask      = mask_q;
    assign leds           = {cal_led, pll_sync_q, state_q};

endmodule

// File: tb/tb_board_reset_sequencer.sv
// Self-checking bench for board_reset_sequencer: directed scenarios plus
// random stimulus against a timestamp-based behavioural model.
module tb_board_reset_sequencer;

    localparam int NM  = 4;
    localparam int DEB = 8;
    localparam int HLD = 4;
    localparam int TO  = 100;

    logic          clk_clk = 1'b0;
    logic          reset_reset;
    logic          pcie_perst_n;
    logic          pll_locked;
    logic [NM-1:0] mem_enable;
    logic [NM-1:0] mem_cal_success;
    logic [NM-1:0] mem_cal_fail;
    logic          global_reset_n;
    logic          mem_reset_n;
    logic          kernel_reset_n;
    logic [2:0]    seq_state;
    logic [1:0]    err_code;
    logic [NM-1:0] fail_mask;
    logic [7:0]    leds;

    int vectors = 0;
    int miscompares = 0;

    // model: phase number, cycle of phase entry, 2-deep sync pipelines
    int            cyc = 0;
    int            m_enter = 0;
    int            m_st = 0;
    logic [1:0]    m_err = '0;
    logic [NM-1:0] m_mask = '0;
    logic          p1 = 1'b0, p2 = 1'b0, l1 = 1'b0, l2 = 1'b0;
    logic [NM-1:0] s1 = '0, s2 = '0, f1 = '0, f2 = '0;

    board_reset_sequencer #(
        .NUM_MEM(NM), .PERST_DEBOUNCE_CYC(DEB),
        .RESET_HOLD_CYC(HLD), .TIMEOUT_CYC(TO)
    ) dut (
        .clk_clk(clk_clk), .reset_reset(reset_reset),
        .pcie_perst_n(pcie_perst_n), .pll_locked(pll_locked),
        .mem_enable(mem_enable), .mem_cal_success(mem_cal_success),
        .mem_cal_fail(mem_cal_fail), .global_reset_n(global_reset_n),
        .mem_reset_n(mem_reset_n), .kernel_reset_n(kernel_reset_n),
        .seq_state(seq_state), .err_code(err_code),
        .fail_mask(fail_mask), .leds(leds)
    );

    always #10 clk_clk = ~clk_clk;

    task automatic model_edge();
        int nx;
        int el;
        logic [NM-1:0] fl;
        logic ok;
        if (reset_reset) begin
            m_st = 0; m_err = '0; m_mask = '0; m_enter = cyc + 1;
            p1 = 0; p2 = 0; l1 = 0; l2 = 0;
            s1 = '0; s2 = '0; f1 = '0; f2 = '0;
        end else begin
            nx = m_st;
            el = cyc - m_enter;
            fl = f2 & mem_enable;
            ok = ((s2 | ~mem_enable) == {NM{1'b1}});
            if (m_st == 0) nx = 1;
            else if (!p2 && m_st != 1) nx = 1;
            else begin
                case (m_st)
                    1: if (p2) nx = 2;
                    2: if (el == DEB - 1) nx = 3;
                    3: if (el == HLD - 1) nx = 4;
                    4: if (l2) nx = 5;
                       else if (el == TO - 1) begin nx = 7; m_err = 2'd1; end
                    5: if (fl != 0) begin nx = 7; m_err = 2'd2; m_mask = fl; end
                       else if (ok) nx = 6;
                       else if (el == TO - 1) begin nx = 7; m_err = 2'd3; end
                    6: if (!l2) nx = 3;
                    default: ;
                endcase
            end
            if (nx == 3 && m_st != 3) begin m_err = '0; m_mask = '0; end
            if (nx != m_st) m_enter = cyc + 1;
            m_st = nx;
            p2 = p1; p1 = pcie_perst_n;
            l2 = l1; l1 = pll_locked;
            s2 = s1; s1 = mem_cal_success;
            f2 = f1; f1 = mem_cal_fail;
        end
        cyc++;
    endtask

    function automatic logic [19:0] exp_vec();
        logic g, m, k;
        g = (m_st >= 4);
        m = (m_st == 5 || m_st == 6);
        k = (m_st == 6);
        return {3'(m_st), m_err, m_mask, g, m, k, s2 & mem_enable, l2, 3'(m_st)};
    endfunction

    function automatic logic [19:0] dut_vec();
        return {seq_state, err_code, fail_mask, global_reset_n,
                mem_reset_n, kernel_reset_n, leds};
    endfunction

    task automatic tick();
        @(posedge clk_clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        reset_reset = 1'b1;
        pcie_perst_n = 1'($urandom_range(0, 1));
        pll_locked = 1'($urandom_range(0, 1));
        mem_enable = 4'hF;
        mem_cal_success = 4'($urandom);
        mem_cal_fail = 4'($urandom);
        repeat (3) tick();
        vectors++;
        if (dut_vec() !== 20'h0) begin
            miscompares++;
            $display("FAIL reset_outputs got=%h want=00000", dut_vec());
        end
        reset_reset = 1'b0;
        pcie_perst_n = 1'b0; pll_locked = 1'b0;
        mem_cal_success = '0; mem_cal_fail = '0;
        tick();
        vectors++;
        if (seq_state !== 3'd1 || dut_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL reset_exit got=%h want=%h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_sequence();
        int trace;
        logic [2:0] last;
        pcie_perst_n = 1'b1;
        last = seq_state;
        trace = int'(seq_state);
        for (int t = 0; t < 500 && m_st != 6; t++) begin
            if (m_st == 4) pll_locked = pll_locked | ($urandom_range(0, 3) == 0);
            if (m_st == 5) mem_cal_success = mem_cal_success | 4'($urandom);
            tick();
            vectors++;
            if (dut_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL seq cyc=%0d got=%h want=%h", cyc, dut_vec(), exp_vec());
            end
            if (seq_state !== last) begin
                last = seq_state;
                if (trace < 10000000) trace = trace * 10 + int'(seq_state);
            end
        end
        vectors++;
        if (trace !== 123456) begin
            miscompares++;
            $display("FAIL seq_order got=%0d want=123456", trace);
        end
        vectors++;
        if (seq_state !== 3'd6 || kernel_reset_n !== 1'b1 || err_code !== 2'd0) begin
            miscompares++;
            $display("FAIL run_outputs got st=%0d krn=%b err=%0d want 6/1/0",
                     seq_state, kernel_reset_n, err_code);
        end
    endtask

    task automatic test_debounce();
        int trace;
        int deb_obs;
        bit glitched;
        logic [2:0] last;
        pcie_perst_n = 1'b0;
        mem_cal_success = '0;
        for (int t = 0; t < 20 && m_st != 1; t++) begin
            tick();
            vectors++;
            if (dut_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL deb_drop cyc=%0d got=%h want=%h", cyc, dut_vec(), exp_vec());
            end
        end
        last = seq_state;
        trace = int'(seq_state);
        glitched = 0;
        deb_obs = 0;
        for (int t = 0; t < 100 && m_st != 3; t++) begin
            if (!glitched && m_st == 2 && cyc - m_enter == 3) begin
                pcie_perst_n = 1'b0;
                glitched = 1;
            end else begin
                pcie_perst_n = 1'b1;
            end
            tick();
            vectors++;
            if (dut_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL deb cyc=%0d got=%h want=%h", cyc, dut_vec(), exp_vec());
            end
            if (seq_state === 3'd2) deb_obs++;
            else if (seq_state === 3'd1) deb_obs = 0;
            if (seq_state !== last) begin
                last = seq_state;
                if (trace < 10000000) trace = trace * 10 + int'(seq_state);
            end
        end
        pcie_perst_n = 1'b1;
        vectors++;
        if (trace !== 12123) begin
            miscompares++;
            $display("FAIL deb_order got=%0d want=12123", trace);
        end
        vectors++;
        if (deb_obs !== DEB) begin
            miscompares++;
            $display("FAIL deb_length got=%0d want=%0d", deb_obs, DEB);
        end
        vectors++;
        if ({global_reset_n, mem_reset_n, kernel_reset_n} !== 3'b000) begin
            miscompares++;
            $display("FAIL hold_resets got=%b want=000",
                     {global_reset_n, mem_reset_n, kernel_reset_n});
        end
    endtask

    task automatic test_cal_fail();
        bit seen_hold;
        for (int t = 0; t < 100 && m_st != 7; t++) begin
            if (m_st == 5) begin
                mem_cal_success = 4'b1011;
                mem_cal_fail = 4'b0100;
            end
            tick();
            vectors++;
            if (dut_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL calf cyc=%0d got=%h want=%h", cyc, dut_vec(), exp_vec());
            end
        end
        vectors++;
        if (seq_state !== 3'd7 || err_code !== 2'd2 || fail_mask !== 4'b0100 ||
            kernel_reset_n !== 1'b0 || global_reset_n !== 1'b1) begin
            miscompares++;
            $display("FAIL calf_error got st=%0d err=%0d mask=%b krn=%b glb=%b want 7/2/0100/0/1",
                     seq_state, err_code, fail_mask, kernel_reset_n, global_reset_n);
        end
        pcie_perst_n = 1'b0;
        mem_cal_fail = '0;
        mem_cal_success = 4'hF;
        for (int t = 0; t < 20 && m_st != 1; t++) tick();
        vectors++;
        if (seq_state !== 3'd1 || err_code !== 2'd2 || global_reset_n !== 1'b0) begin
            miscompares++;
            $display("FAIL err_sticky got st=%0d err=%0d glb=%b want 1/2/0",
                     seq_state, err_code, global_reset_n);
        end
        pcie_perst_n = 1'b1;
        seen_hold = 0;
        for (int t = 0; t < 200 && m_st != 6; t++) begin
            tick();
            vectors++;
            if (dut_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL reseq cyc=%0d got=%h want=%h", cyc, dut_vec(), exp_vec());
            end
            if (!seen_hold && seq_state === 3'd3) begin
                seen_hold = 1;
                vectors++;
                if (err_code !== 2'd0 || fail_mask !== 4'b0000) begin
                    miscompares++;
                    $display("FAIL hold_clear got err=%0d mask=%b want 0/0000",
                             err_code, fail_mask);
                end
            end
        end
        vectors++;
        if (seq_state !== 3'd6) begin
            miscompares++;
            $display("FAIL reseq_run got=%0d want=6", seq_state);
        end
    endtask

    task automatic test_pll_drop();
        int edges;
        pll_locked = 1'b0;
        edges = 0;
        for (int t = 0; t < 20 && seq_state !== 3'd3; t++) begin
            tick();
            edges++;
            vectors++;
            if (dut_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL drop cyc=%0d got=%h want=%h", cyc, dut_vec(), exp_vec());
            end
        end
        vectors++;
        if (edges !== 3 || {global_reset_n, mem_reset_n, kernel_reset_n} !== 3'b000) begin
            miscompares++;
            $display("FAIL drop_latency got edges=%0d rst=%b want 3/000", edges,
                     {global_reset_n, mem_reset_n, kernel_reset_n});
        end
        pll_locked = 1'b1;
        for (int t = 0; t < 200 && m_st != 6; t++) begin
            tick();
            vectors++;
            if (dut_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL relock cyc=%0d got=%h want=%h", cyc, dut_vec(), exp_vec());
            end
        end
        vectors++;
        if (seq_state !== 3'd6 || kernel_reset_n !== 1'b1) begin
            miscompares++;
            $display("FAIL relock_run got st=%0d krn=%b want 6/1", seq_state, kernel_reset_n);
        end
    endtask

    task automatic test_pll_timeout();
        int n4;
        pll_locked = 1'b0;
        n4 = 0;
        for (int t = 0; t < 300 && seq_state !== 3'd7; t++) begin
            tick();
            vectors++;
            if (dut_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL pllto cyc=%0d got=%h want=%h", cyc, dut_vec(), exp_vec());
            end
            if (seq_state === 3'd4) n4++;
        end
        vectors++;
        if (n4 !== TO || err_code !== 2'd1 || global_reset_n !== 1'b1 ||
            mem_reset_n !== 1'b0 || kernel_reset_n !== 1'b0) begin
            miscompares++;
            $display("FAIL pll_timeout got n=%0d err=%0d rst=%b want %0d/1/100", n4,
                     err_code, {global_reset_n, mem_reset_n, kernel_reset_n}, TO);
        end
    endtask

    task automatic test_fail_priority();
        pcie_perst_n = 1'b0;
        for (int t = 0; t < 20 && m_st != 1; t++) tick();
        pcie_perst_n = 1'b1;
        pll_locked = 1'b1;
        mem_cal_success = 4'hF;
        mem_cal_fail = 4'b0010;
        for (int t = 0; t < 200 && m_st != 7; t++) begin
            tick();
            vectors++;
            if (dut_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL prio cyc=%0d got=%h want=%h", cyc, dut_vec(), exp_vec());
            end
        end
        vectors++;
        if (seq_state !== 3'd7 || err_code !== 2'd2 || fail_mask !== 4'b0010) begin
            miscompares++;
            $display("FAIL fail_beats_success got st=%0d err=%0d mask=%b want 7/2/0010",
                     seq_state, err_code, fail_mask);
        end
    endtask

    task automatic test_no_mem();
        int n5;
        pcie_perst_n = 1'b0;
        for (int t = 0; t < 20 && m_st != 1; t++) tick();
        mem_enable = 4'h0;
        mem_cal_success = '0;
        mem_cal_fail = 4'hF;
        pcie_perst_n = 1'b1;
        n5 = 0;
        for (int t = 0; t < 200 && seq_state !== 3'd6; t++) begin
            tick();
            vectors++;
            if (dut_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL nomem cyc=%0d got=%h want=%h", cyc, dut_vec(), exp_vec());
            end
            if (seq_state === 3'd5) n5++;
        end
        vectors++;
        if (n5 !== 1 || kernel_reset_n !== 1'b1 || leds[7:4] !== 4'h0) begin
            miscompares++;
            $display("FAIL no_mem got calcyc=%0d krn=%b led=%h want 1/1/0",
                     n5, kernel_reset_n, leds[7:4]);
        end
        mem_cal_fail = '0;
        mem_enable = 4'hF;
    endtask

    task automatic test_reset_in_cal();
        pcie_perst_n = 1'b0;
        mem_cal_success = '0;
        mem_cal_fail = '0;
        for (int t = 0; t < 20 && m_st != 1; t++) tick();
        pcie_perst_n = 1'b1;
        pll_locked = 1'b1;
        for (int t = 0; t < 200 && m_st != 5; t++) begin
            tick();
            vectors++;
            if (dut_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL rcal cyc=%0d got=%h want=%h", cyc, dut_vec(), exp_vec());
            end
        end
        mem_cal_success = 4'hF;
        mem_cal_fail = 4'hF;
        reset_reset = 1'b1;
        tick();
        vectors++;
        if (dut_vec() !== 20'h0 || dut_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL reset_in_cal got=%h want=00000", dut_vec());
        end
        reset_reset = 1'b0;
        mem_cal_fail = '0;
        tick();
        vectors++;
        if (seq_state !== 3'd1 || dut_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL reset_in_cal_exit got=%h want=%h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 4000; i++) begin
            if (i % 500 == 0) mem_enable = 4'($urandom);
            reset_reset = ($urandom_range(0, 299) == 0);
            pcie_perst_n = ($urandom_range(0, 99) < 97);
            if ($urandom_range(0, 49) == 0) pll_locked = ~pll_locked;
            mem_cal_success = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom);
            mem_cal_fail = ($urandom_range(0, 79) == 0) ? 4'($urandom) : 4'h0;
            tick();
            vectors++;
            if (dut_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL rand i=%0d got=%h want=%h", i, dut_vec(), exp_vec());
            end
        end
        reset_reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_debounce();
        test_cal_fail();
        test_pll_drop();
        test_pll_timeout();
        test_fail_priority();
        test_no_mem();
        test_reset_in_cal();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
